// File: rtl/calc_controller.sv
// ----------------------------------------------------------------------------
// calc_controller
//
// Walks a block of operand memory two words at a time (A at even offset,
// B at odd offset), adds each pair with adder32 and writes the truncated sum
// to a separate result region. Pulses done_o when the last complete pair has
// been written. A trailing unpaired operand is never read.
//
// Ports
//   clk_i               clock, rising edge
//   rst_ni              asynchronous active-low reset
//   start_i             begin a run (sampled only while idle)
//   read_start_addr_i   first operand address (latched at start)
//   read_end_addr_i     last operand address, inclusive (latched at start)
//   write_start_addr_i  first result address (latched at start)
//   rd_en_o/rd_addr_o   memory read strobe/address (data returns next cycle)
//   rd_data_i           memory read data
//   wr_en_o/wr_addr_o/wr_data_o  memory write strobe/address/data
//   busy_o              high whenever not idle
//   done_o              one-cycle end-of-run pulse
//   pair_count_o        results written in the current or last run
// ----------------------------------------------------------------------------

package calculator_pkg;
    parameter int DATA_W = 32;
endpackage

// Shared 32-bit adder; carry out is discarded.
module adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    assign sum_o = a_i + b_i;
endmodule

module calc_controller #(
    parameter int DATA_W = calculator_pkg::DATA_W,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] read_start_addr_i,
    input  logic [ADDR_W-1:0] read_end_addr_i,
    input  logic [ADDR_W-1:0] write_start_addr_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] pair_count_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ_A = 3'd1,
        S_READ_B = 3'd2,
        S_ADD    = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Read pointer carries one extra bit so a pair ending at the top address
    // compares past read_end instead of wrapping back to address 0.
    logic [ADDR_W:0]   rd_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] read_end_q;
    logic [ADDR_W-1:0] pair_count_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] sum;

    logic [ADDR_W:0]   start_b_addr;   // read_start + 1, widened
    logic [ADDR_W:0]   rd_ptr_adv;     // rd_ptr + 2 (next pair's A)
    logic [ADDR_W:0]   next_b_addr;    // rd_ptr + 3 (next pair's B)
    logic [ADDR_W-1:0] cur_b_addr;     // address of current pair's B

    assign start_b_addr = {1'b0, read_start_addr_i} + {{ADDR_W{1'b0}}, 1'b1};
    assign rd_ptr_adv   = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 2'd2};
    assign next_b_addr  = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 2'd3};
    assign cur_b_addr   = rd_ptr_q[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1};

    adder32 u_adder (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (sum)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (start_b_addr <= {1'b0, read_end_addr_i}) ? S_READ_A : S_DONE;
                end
            end
            S_READ_A: state_d = S_READ_B;
            S_READ_B: state_d = S_ADD;
            S_ADD:    state_d = S_WRITE;
            S_WRITE: begin
                state_d = (next_b_addr <= {1'b0, read_end_q}) ? S_READ_A : S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode; address/data buses are zero when their strobe is low
    // ------------------------------------------------------------------
    always_comb begin
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        done_o    = 1'b0;
        busy_o    = (state_q != S_IDLE);
        case (state_q)
            S_READ_A: begin
                rd_en_o   = 1'b1;
                rd_addr_o = rd_ptr_q[ADDR_W-1:0];
            end
            S_READ_B: begin
                rd_en_o   = 1'b1;
                rd_addr_o = cur_b_addr;
            end
            S_WRITE: begin
                wr_en_o   = 1'b1;
                wr_addr_o = wr_ptr_q;
                wr_data_o = sum;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign pair_count_o = pair_count_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            read_end_q   <= '0;
            pair_count_q <= '0;
            a_q          <= '0;
            b_q          <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rd_ptr_q     <= {1'b0, read_start_addr_i};
                        wr_ptr_q     <= write_start_addr_i;
                        read_end_q   <= read_end_addr_i;
                        pair_count_q <= '0;
                    end
                end
                // Data for the READ_A address arrives during READ_B.
                S_READ_B: a_q <= rd_data_i;
                S_ADD:    b_q <= rd_data_i;
                S_WRITE: begin
                    rd_ptr_q     <= rd_ptr_adv;
                    wr_ptr_q     <= wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    pair_count_q <= pair_count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_controller.sv
module tb_calc_controller;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] rs_addr, re_addr, ws_addr;
    logic              rd_en, wr_en, busy, done;
    logic [ADDR_W-1:0] rd_addr, wr_addr, pair_count;
    logic [DATA_W-1:0] rd_data, wr_data;

    logic [DATA_W-1:0] mem [0:1023];

    logic [ADDR_W-1:0] rd_log[$];
    logic [ADDR_W-1:0] wa_log[$];
    logic [DATA_W-1:0] wd_log[$];
    int strobe_err;

    int n_cmp = 0;
    int n_err = 0;

    calc_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .start_i            (start),
        .read_start_addr_i  (rs_addr),
        .read_end_addr_i    (re_addr),
        .write_start_addr_i (ws_addr),
        .rd_en_o            (rd_en),
        .rd_addr_o          (rd_addr),
        .rd_data_i          (rd_data),
        .wr_en_o            (wr_en),
        .wr_addr_o          (wr_addr),
        .wr_data_o          (wr_data),
        .busy_o             (busy),
        .done_o             (done),
        .pair_count_o       (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Record one cycle of bus activity (called at negedge).
    task automatic observe();
        if (rd_en) rd_log.push_back(rd_addr);
        if (wr_en) begin
            wa_log.push_back(wr_addr);
            wd_log.push_back(wr_data);
            $display("  write addr=%0d data=0x%08h", wr_addr, wr_data);
        end
        if (rd_en && wr_en) strobe_err++;
        if (!rd_en && rd_addr != 0) strobe_err++;
        if (!wr_en && (wr_addr != 0 || wr_data != 0)) strobe_err++;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
        strobe_err = 0;
    endtask

    // Start a run from a negedge; cycle k is the k-th negedge after the
    // sampling edge. Addresses are scrambled after start to check latching.
    task automatic run(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] re,
                       input logic [ADDR_W-1:0] ws, input int max_cyc,
                       output int done_cyc);
        clear_logs();
        done_cyc = -1;
        rs_addr = rs; re_addr = re; ws_addr = ws;
        start = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            start = 1'b0;
            rs_addr = ~rs; re_addr = 10'd0; ws_addr = ~ws;
            observe();
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        rs_addr = '0; re_addr = '0; ws_addr = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({rd_en, wr_en, busy, done} !== 4'b0) begin n_err++;
            $display("FAIL reset_strobes got=%b want=0000", {rd_en, wr_en, busy, done}); end
        n_cmp++; if (pair_count !== 10'd0) begin n_err++;
            $display("FAIL reset_pair_count got=%0d want=0", pair_count); end
        n_cmp++; if ({rd_addr, wr_addr, wr_data} !== 52'd0) begin n_err++;
            $display("FAIL reset_buses got=%h want=0", {rd_addr, wr_addr, wr_data}); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: checked");
    endtask

    task automatic test_single_pair();
        int dc;
        mem[0] = 32'd5; mem[1] = 32'd7;
        run(10'd0, 10'd1, 10'd16, 40, dc);
        $display("single_pair: done_cycle=%0d writes=%0d", dc, wa_log.size());
        n_cmp++; if (dc != 5) begin n_err++;
            $display("FAIL single_done_cycle got=%0d want=5", dc); end
        n_cmp++; if (wa_log.size() != 1) begin n_err++;
            $display("FAIL single_write_count got=%0d want=1", wa_log.size()); end
        else begin
            n_cmp++; if (wa_log[0] !== 10'd16 || wd_log[0] !== 32'd12) begin n_err++;
                $display("FAIL single_write got=%0d@%0d want=12@16", wd_log[0], wa_log[0]); end
        end
        n_cmp++; if (pair_count !== 10'd1) begin n_err++;
            $display("FAIL single_pair_count got=%0d want=1", pair_count); end
        n_cmp++; if (rd_log.size() != 2 || rd_log[0] !== 10'd0 || rd_log[1] !== 10'd1) begin n_err++;
            $display("FAIL single_reads got_count=%0d want=2 (0,1)", rd_log.size()); end
        n_cmp++; if (strobe_err != 0 || busy !== 1'b0) begin n_err++;
            $display("FAIL single_strobes got_err=%0d busy=%b want=0/0", strobe_err, busy); end
    endtask

    task automatic test_overflow();
        int dc;
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd2;
        run(10'd0, 10'd1, 10'd20, 40, dc);
        $display("overflow: done_cycle=%0d writes=%0d", dc, wa_log.size());
        n_cmp++; if (wa_log.size() != 1) begin n_err++;
            $display("FAIL overflow_write_count got=%0d want=1", wa_log.size()); end
        else begin
            n_cmp++; if (wd_log[0] !== 32'h0000_0001 || wa_log[0] !== 10'd20) begin n_err++;
                $display("FAIL overflow_data got=0x%08h@%0d want=0x00000001@20", wd_log[0], wa_log[0]); end
        end
    endtask

    task automatic test_odd_count();
        int dc;
        bit saw4;
        mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4; mem[4] = 32'd9;
        run(10'd0, 10'd4, 10'd32, 60, dc);
        $display("odd_count: done_cycle=%0d writes=%0d", dc, wa_log.size());
        saw4 = 0;
        foreach (rd_log[i]) if (rd_log[i] == 10'd4) saw4 = 1;
        n_cmp++; if (dc != 9) begin n_err++;
            $display("FAIL odd_done_cycle got=%0d want=9", dc); end
        n_cmp++; if (wa_log.size() != 2) begin n_err++;
            $display("FAIL odd_write_count got=%0d want=2", wa_log.size()); end
        else begin
            n_cmp++; if (wa_log[0] !== 10'd32 || wd_log[0] !== 32'd3) begin n_err++;
                $display("FAIL odd_write0 got=%0d@%0d want=3@32", wd_log[0], wa_log[0]); end
            n_cmp++; if (wa_log[1] !== 10'd33 || wd_log[1] !== 32'd7) begin n_err++;
                $display("FAIL odd_write1 got=%0d@%0d want=7@33", wd_log[1], wa_log[1]); end
        end
        n_cmp++; if (saw4 || rd_log.size() != 4) begin n_err++;
            $display("FAIL odd_reads got_count=%0d read4=%0d want=4/0", rd_log.size(), saw4); end
        n_cmp++; if (pair_count !== 10'd2) begin n_err++;
            $display("FAIL odd_pair_count got=%0d want=2", pair_count); end
    endtask

    task automatic test_zero_pairs();
        int dc;
        run(10'd5, 10'd5, 10'd0, 20, dc);
        $display("zero_pairs: done_cycle=%0d reads=%0d writes=%0d", dc, rd_log.size(), wa_log.size());
        n_cmp++; if (dc != 1) begin n_err++;
            $display("FAIL zero_done_cycle got=%0d want=1", dc); end
        n_cmp++; if (rd_log.size() != 0 || wa_log.size() != 0) begin n_err++;
            $display("FAIL zero_activity got_reads=%0d writes=%0d want=0/0", rd_log.size(), wa_log.size()); end
        n_cmp++; if (pair_count !== 10'd0) begin n_err++;
            $display("FAIL zero_pair_count got=%0d want=0", pair_count); end
    endtask

    task automatic test_top_of_memory();
        int dc;
        mem[1022] = 32'd100; mem[1023] = 32'd23; mem[0] = 32'd1000;
        run(10'd1022, 10'd1023, 10'd7, 40, dc);
        $display("top_of_memory: done_cycle=%0d writes=%0d", dc, wa_log.size());
        n_cmp++; if (dc != 5) begin n_err++;
            $display("FAIL top_done_cycle got=%0d want=5", dc); end
        n_cmp++; if (wa_log.size() != 1) begin n_err++;
            $display("FAIL top_write_count got=%0d want=1", wa_log.size()); end
        else begin
            n_cmp++; if (wa_log[0] !== 10'd7 || wd_log[0] !== 32'd123) begin n_err++;
                $display("FAIL top_write got=%0d@%0d want=123@7", wd_log[0], wa_log[0]); end
        end
        n_cmp++; if (rd_log.size() != 2 || rd_log[0] !== 10'd1022 || rd_log[1] !== 10'd1023) begin n_err++;
            $display("FAIL top_reads got_count=%0d want=2 (1022,1023)", rd_log.size()); end
    endtask

    // start_i held high: second run must begin only after the IDLE cycle
    // following DONE (READ_A of run 2 is cycle first_done+2).
    task automatic test_back_to_back();
        int first_done, second_done;
        logic busy_h [0:31];
        logic rden_h [0:31];
        logic [ADDR_W-1:0] rda_h [0:31];
        first_done = -1; second_done = -1;
        mem[0] = 32'd11; mem[1] = 32'd22;
        clear_logs();
        rs_addr = 10'd0; re_addr = 10'd1; ws_addr = 10'd40;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            observe();
            busy_h[k] = busy; rden_h[k] = rd_en; rda_h[k] = rd_addr;
            if (first_done >= 0 && k == first_done + 2) start = 1'b0;
            if (done) begin
                if (first_done < 0) first_done = k;
                else begin second_done = k; break; end
            end
        end
        start = 1'b0;
        @(negedge clk);
        $display("back_to_back: first_done=%0d second_done=%0d writes=%0d",
                 first_done, second_done, wa_log.size());
        n_cmp++; if (first_done != 5) begin n_err++;
            $display("FAIL b2b_first_done got=%0d want=5", first_done); end
        n_cmp++; if (second_done != 11) begin n_err++;
            $display("FAIL b2b_second_done got=%0d want=11", second_done); end
        if (first_done == 5) begin
            n_cmp++; if (busy_h[6] !== 1'b0 || busy_h[7] !== 1'b1) begin n_err++;
                $display("FAIL b2b_idle_gap got_busy6=%b busy7=%b want=0/1", busy_h[6], busy_h[7]); end
            n_cmp++; if (rden_h[7] !== 1'b1 || rda_h[7] !== 10'd0) begin n_err++;
                $display("FAIL b2b_restart_read got_en=%b addr=%0d want=1/0", rden_h[7], rda_h[7]); end
        end
        n_cmp++; if (wa_log.size() != 2) begin n_err++;
            $display("FAIL b2b_write_count got=%0d want=2", wa_log.size()); end
        else begin
            n_cmp++; if (wd_log[1] !== 32'd33 || wa_log[1] !== 10'd40) begin n_err++;
                $display("FAIL b2b_write got=%0d@%0d want=33@40", wd_log[1], wa_log[1]); end
        end
    endtask

    task automatic test_reset_mid_run();
        int dc;
        int wr_after;
        mem[0] = 32'd10; mem[1] = 32'd20; mem[2] = 32'd30;
        mem[3] = 32'd40; mem[4] = 32'd50; mem[5] = 32'd60;
        clear_logs();
        rs_addr = 10'd0; re_addr = 10'd5; ws_addr = 10'd50;
        start = 1'b1;
        // Pair 1: cycles 1-4; pair 2: READ_A 5, READ_B 6, ADD 7.
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            observe();
        end
        n_cmp++; if (wa_log.size() != 1 || wd_log[0] !== 32'd30 || wa_log[0] !== 10'd50) begin n_err++;
            $display("FAIL midrst_first_write got_count=%0d want=1 (30@50)", wa_log.size()); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({rd_en, wr_en, busy, done} !== 4'b0 || pair_count !== 10'd0) begin n_err++;
            $display("FAIL midrst_outputs got=%b pc=%0d want=0000 pc=0", {rd_en, wr_en, busy, done}, pair_count); end
        wr_after = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wr_en || done || busy) wr_after++;
        end
        n_cmp++; if (wr_after != 0) begin n_err++;
            $display("FAIL midrst_quiet got=%0d active cycles want=0", wr_after); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset_mid_run: aborted, restarting");
        run(10'd0, 10'd1, 10'd60, 40, dc);
        n_cmp++; if (dc != 5 || wa_log.size() != 1) begin n_err++;
            $display("FAIL midrst_rerun got_done=%0d writes=%0d want=5/1", dc, wa_log.size()); end
        else begin
            n_cmp++; if (wd_log[0] !== 32'd30 || wa_log[0] !== 10'd60) begin n_err++;
                $display("FAIL midrst_rerun_write got=%0d@%0d want=30@60", wd_log[0], wa_log[0]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        rd_data = '0;
        test_reset();
        test_single_pair();
        test_overflow();
        test_odd_count();
        test_zero_pairs();
        test_top_of_memory();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/calc_controller.md
# calc_controller

Sequencer that drives the shared 32-bit adder over a block of operand memory. On `start_i` it reads consecutive word pairs (A at even offset, B at odd offset) from a synchronous-read memory and feeds each pair to `adder32`. It writes each truncated 32-bit sum to a separate write region, then pulses `done_o`. It sits between the calculator top level and the operand/result SRAM and instantiates `adder32` internally.

## Interface
- `DATA_W`, 32 (from `calculator_pkg`): operand/result width.
- `ADDR_W`, 10: memory address width.

- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  begin a run; sampled only in IDLE.
- `read_start_addr_i`  in  ADDR_W  first operand address; latched at start.
- `read_end_addr_i`  in  ADDR_W  last operand address, inclusive; latched at start.
- `write_start_addr_i`  in  ADDR_W  first result address; latched at start.
- `rd_en_o`  out  1  memory read strobe.
- `rd_addr_o`  out  ADDR_W  read address.
- `rd_data_i`  in  DATA_W  read data, valid the cycle after `rd_en_o`.
- `wr_en_o`  out  1  memory write strobe.
- `wr_addr_o`  out  ADDR_W  write address.
- `wr_data_o`  out  DATA_W  write data (sum).
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse at end of run.
- `pair_count_o`  out  ADDR_W  results written in the current or last run.

## Operation
- **States:** IDLE, READ_A, READ_B, ADD, WRITE, DONE.
- **IDLE:** if `start_i`, latch the three addresses and set `rd_ptr` to `read_start`, `wr_ptr` to `write_start`, `pair_count_o` to 0.
  - Go to READ_A if `read_start + 1 <= read_end`; otherwise go to DONE with zero writes.
- **READ_A:** `rd_en_o`=1, `rd_addr_o`=`rd_ptr`. Next state READ_B.
- **READ_B:** `rd_en_o`=1, `rd_addr_o`=`rd_ptr+1`; capture `rd_data_i` into `a_q`. Next state ADD.
- **ADD:** capture `rd_data_i` into `b_q`. Next state WRITE.
- **WRITE:** `wr_en_o`=1, `wr_addr_o`=`wr_ptr`, `wr_data_o` = `adder32(a_q, b_q)`.
  - Update `rd_ptr += 2`, `wr_ptr += 1`, `pair_count_o += 1`.
  - Go to READ_A if `new rd_ptr + 1 <= read_end`; otherwise go to DONE.
- **DONE:** `done_o`=1 for one cycle, then IDLE.
- **Arithmetic:** sum is mod 2^DATA_W; carry is discarded.
- **Pointer width:** `rd_ptr` comparison is done in ADDR_W+1 bits, so a pair ending at the top address terminates instead of wrapping. `wr_ptr` wraps mod 2^ADDR_W.
- **Odd operand count:** the final unpaired word is never read.
- **Start while busy:** ignored. Latched addresses do not change mid-run.
- **Read/write overlap:** write region overlapping read region is legal. Each result is written after both of its operands are captured.
- **Strobes:** `rd_en_o` and `wr_en_o` are never high in the same cycle. `rd_addr_o`, `wr_addr_o` and `wr_data_o` are 0 whenever their strobe is low.

## Timing
- **Reset values:** state IDLE; every output 0, including `pair_count_o`, `busy_o` and `done_o`. `a_q`, `b_q` and pointers are 0.
- **Reset mid-run:** abort immediately (asynchronous). No further reads or writes; no `done_o`.
- **Start:** sampled at edge E0; READ_A is active in the following cycle.
- **Throughput:** 4 cycles per pair (READ_A, READ_B, ADD, WRITE).
- **N pairs:** `done_o` is high in cycle E0+4N+1. With zero pairs, `done_o` is high in cycle E0+1.
- **Back-to-back runs:** the earliest next start is sampled in the IDLE cycle after DONE. `start_i` during the DONE cycle is ignored.
- `pair_count_o` holds its final value until the next accepted start.

## Test plan
- **Single pair:** mem[0]=5, mem[1]=7; start with read 0..1, write 16. Expect `wr_en_o` once with addr 16, data 12; `done_o` at E0+5; `pair_count_o`=1.
- **Overflow:** mem[0]=0xFFFF_FFFF, mem[1]=2; start. Expect data 0x0000_0001.
- **Odd count:** read 0..4 holding 1,2,3,4,9; write 32. Expect writes 3@32 and 7@33; address 4 never read; `done_o` at E0+9; `pair_count_o`=2.
- **Zero pairs:** read 5..5. Expect no `rd_en_o` or `wr_en_o`; `done_o` at E0+1; `pair_count_o`=0.
- **Top-of-memory:** read 1022..1023. Expect exactly one pair and clean termination, no wrap to address 0. Separately, `start_i` held high throughout is re-accepted only after DONE.
- **Reset mid-run:** assert `rst_ni` low during the ADD of pair 2 of 3. Expect all outputs 0 immediately, no further writes, then a normal run after release.
